// File: rtl/rggen_host_if_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rggen_host_if_apb_ctrl
// Purpose  : Registered APB slave front-end with base decode, alignment check,
//            response capture and optional BUSY timeout (RGGEN_APB_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module rggen_host_if_apb_ctrl #(
    parameter int                         ADDRESS_WIDTH       = 32,
    parameter int                         LOCAL_ADDRESS_WIDTH = 16,
    parameter int                         DATA_WIDTH          = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS        = '0,
    parameter int                         TIMEOUT_CYCLES      = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             psel,
    input  logic                             penable,
    input  logic [ADDRESS_WIDTH-1:0]         paddr,
    input  logic                             pwrite,
    input  logic [DATA_WIDTH-1:0]            pwdata,
    input  logic [DATA_WIDTH/8-1:0]          pstrb,
    output logic                             pready,
    output logic [DATA_WIDTH-1:0]            prdata,
    output logic                             pslverr,
    output logic                             bus_request,
    output logic [LOCAL_ADDRESS_WIDTH-1:0]   bus_address,
    output logic                             bus_direction,
    output logic [DATA_WIDTH-1:0]            bus_write_data,
    output logic [DATA_WIDTH/8-1:0]          bus_write_strobe,
    input  logic                             bus_done,
    input  logic [DATA_WIDTH-1:0]            bus_read_data,
    input  logic [1:0]                       bus_status
);

    localparam int c_strb_width = DATA_WIDTH / 8;
    localparam int c_align_bits = $clog2(c_strb_width);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_setup;
    logic                    w_base_hit;
    logic                    w_aligned;
    logic                    w_decode_ok;
    logic                    w_abort;
    logic                    w_timeout;
    logic                    r_aborted;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    w_unused_status;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_data_width_range
        $error("DATA_WIDTH must be a non-zero multiple of 8");
    end

    // Only bit 1 of the downstream status carries meaning.
    assign w_unused_status = bus_status[0];

    assign w_setup = psel & ~penable;

    if (LOCAL_ADDRESS_WIDTH < ADDRESS_WIDTH) begin : g_base
        assign w_base_hit = (paddr[ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH] ==
                             BASE_ADDRESS[ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH]);
    end else begin : g_no_base
        assign w_base_hit = 1'b1;
    end

    if (c_align_bits > 0) begin : g_align
        assign w_aligned = (paddr[c_align_bits-1:0] == '0);
    end else begin : g_no_align
        assign w_aligned = 1'b1;
    end

    assign w_decode_ok = w_base_hit & w_aligned;

    // A master that lets go of psel mid-access forfeits the response.
    assign w_abort = r_aborted | ~psel;

`ifdef RGGEN_APB_TIMEOUT_EN
    localparam int                      c_count_width = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_count_width-1:0] c_count_one   = 1;
    localparam logic [c_count_width-1:0] c_count_limit = c_count_width'(TIMEOUT_CYCLES);

    logic [c_count_width-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_state == ST_BUSY) begin
            r_count <= r_count + c_count_one;
        end else begin
            r_count <= '0;
        end
    end

    // Expiry is the cycle in which the counter would step onto the limit.
    assign w_timeout = (r_state == ST_BUSY) && ((r_count + c_count_one) == c_count_limit);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_state_next = w_decode_ok ? ST_BUSY : ST_RESP;
                end
            end
            ST_BUSY: begin
                if (bus_done || w_timeout) begin
                    w_state_next = w_abort ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_request <= 1'b0;
        end else begin
            bus_request <= (w_state_next == ST_BUSY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_address      <= '0;
            bus_direction    <= 1'b0;
            bus_write_data   <= '0;
            bus_write_strobe <= '0;
            r_aborted        <= 1'b0;
            r_err            <= 1'b0;
            r_rdata          <= '0;
        end else begin
            if (r_state == ST_IDLE && w_setup) begin
                bus_address      <= paddr[LOCAL_ADDRESS_WIDTH-1:0];
                bus_direction    <= pwrite;
                bus_write_data   <= pwdata;
                bus_write_strobe <= pwrite ? pstrb : '0;
                r_aborted        <= 1'b0;
                if (!w_decode_ok) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end
            end
            if (r_state == ST_BUSY) begin
                if (!psel) begin
                    r_aborted <= 1'b1;
                end
                // A completion landing in the expiry cycle takes priority.
                if (bus_done) begin
                    r_err   <= bus_status[1];
                    r_rdata <= bus_direction ? '0 : bus_read_data;
                end else if (w_timeout) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end
            end
        end
    end

    assign pready  = (r_state == ST_RESP);
    assign pslverr = pready & r_err;
    assign prdata  = (pready && !r_err) ? r_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_rggen_host_if_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rggen_host_if_apb_ctrl
// Purpose  : Scoreboard bench: directed APB accesses, queued expectations,
//            independent response/request monitors and a downstream responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rggen_host_if_apb_ctrl;

    localparam int AW  = 32;
    localparam int LAW = 16;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TO  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            psel;
    logic            penable;
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [SW-1:0]   pstrb;
    logic            pready;
    logic [DW-1:0]   prdata;
    logic            pslverr;
    logic            bus_request;
    logic [LAW-1:0]  bus_address;
    logic            bus_direction;
    logic [DW-1:0]   bus_write_data;
    logic [SW-1:0]   bus_write_strobe;
    logic            bus_done;
    logic [DW-1:0]   bus_read_data;
    logic [1:0]      bus_status;

    always #5 clk = ~clk;

    rggen_host_if_apb_ctrl #(
        .ADDRESS_WIDTH       (AW),
        .LOCAL_ADDRESS_WIDTH (LAW),
        .DATA_WIDTH          (DW),
        .BASE_ADDRESS        ('0),
        .TIMEOUT_CYCLES      (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .psel             (psel),
        .penable          (penable),
        .paddr            (paddr),
        .pwrite           (pwrite),
        .pwdata           (pwdata),
        .pstrb            (pstrb),
        .pready           (pready),
        .prdata           (prdata),
        .pslverr          (pslverr),
        .bus_request      (bus_request),
        .bus_address      (bus_address),
        .bus_direction    (bus_direction),
        .bus_write_data   (bus_write_data),
        .bus_write_strobe (bus_write_strobe),
        .bus_done         (bus_done),
        .bus_read_data    (bus_read_data),
        .bus_status       (bus_status)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    typedef struct {
        logic [LAW-1:0] addr;
        logic           dir;
        logic [DW-1:0]  wdata;
        logic [SW-1:0]  strb;
    } req_t;

    rsp_t rsp_q[$];
    req_t req_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int            rsp_delay = -1;
    logic [DW-1:0] rsp_data  = '0;
    logic [1:0]    rsp_stat  = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Downstream responder: pulses bus_done rsp_delay cycles after request rises.
    initial begin
        bit armed;
        int cnt;
        armed         = 1'b0;
        cnt           = 0;
        bus_done      = 1'b0;
        bus_read_data = 32'hBAD0_BAD0;
        bus_status    = 2'b11;
        forever begin
            @(negedge clk);
            if (bus_done) begin
                bus_done      = 1'b0;
                bus_read_data = 32'hBAD0_BAD0;
                bus_status    = 2'b11;
                armed         = 1'b0;
            end else if (bus_request) begin
                if (!armed) begin
                    armed = 1'b1;
                    cnt   = 0;
                end else begin
                    cnt++;
                end
                if (cnt == rsp_delay) begin
                    bus_done      = 1'b1;
                    bus_read_data = rsp_data;
                    bus_status    = rsp_stat;
                end
            end else begin
                armed = 1'b0;
            end
        end
    end

    // Monitor: APB responses and downstream request launches against the queues.
    initial begin
        rsp_t e;
        req_t r;
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pready) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_pready", pready, 0);
                    end else begin
                        e = rsp_q.pop_front();
                        check("prdata", prdata, e.rdata);
                        check("pslverr", pslverr, e.err);
                    end
                end else begin
                    check("idle_prdata", prdata, 0);
                    check("idle_pslverr", pslverr, 0);
                end
                if (bus_request && !prev_req) begin
                    if (req_q.size() == 0) begin
                        check("unexpected_request", bus_request, 0);
                    end else begin
                        r = req_q.pop_front();
                        check("bus_address", bus_address, r.addr);
                        check("bus_direction", bus_direction, r.dir);
                        check("bus_write_data", bus_write_data, r.wdata);
                        check("bus_write_strobe", bus_write_strobe, r.strb);
                    end
                end
            end
            prev_req = bus_request;
        end
    end

    task automatic apb(input string name, input logic [AW-1:0] addr, input logic wr,
                       input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                       input int delay, input logic [DW-1:0] d_rsp, input logic [1:0] s_rsp,
                       input logic [DW-1:0] exp_d, input logic exp_e, input bit exp_req,
                       input int exp_cycles);
        rsp_t e;
        req_t r;
        int   cycles;
        bit   got;
        rsp_delay = delay;
        rsp_data  = d_rsp;
        rsp_stat  = s_rsp;
        e.rdata   = exp_d;
        e.err     = exp_e;
        rsp_q.push_back(e);
        if (exp_req) begin
            r.addr  = addr[LAW-1:0];
            r.dir   = wr;
            r.wdata = wdata;
            r.strb  = wr ? strb : '0;
            req_q.push_back(r);
        end
        @(posedge clk); #1;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        pstrb   = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        cycles  = 0;
        got     = 1'b0;
        while (!got && cycles < 64) begin
            @(negedge clk);
            cycles++;
            if (pready) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        check({name, "_access_cycles"}, cycles, exp_cycles);
    endtask

    initial begin
        int seen;
        rst     = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        paddr   = '0;
        pwrite  = 1'b0;
        pwdata  = '0;
        pstrb   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", pready, 0);
        check("rst_pslverr", pslverr, 0);
        check("rst_bus_request", bus_request, 0);
        check("rst_prdata", prdata, 0);
        check("rst_bus_address", bus_address, 0);
        check("rst_bus_write_strobe", bus_write_strobe, 0);
        rst = 1'b0;

        //   name           addr          wr    wdata          strb   dly  rsp_data       st     exp_d          err  req  cyc
        apb("write",       32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'h3,   2, 32'hCAFE_F00D, 2'b00, 32'h0000_0000, 1'b0, 1,   4);
        apb("read",        32'h0000_0004, 1'b0, 32'h1111_1111, 4'hF,   0, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0, 1,   2);
        apb("base_err",    32'h0001_0000, 1'b0, 32'h0,         4'h0,   0, 32'h7777_7777, 2'b00, 32'h0000_0000, 1'b1, 0,   1);
        apb("align_err",   32'h0000_0002, 1'b0, 32'h0,         4'h0,   0, 32'h7777_7777, 2'b00, 32'h0000_0000, 1'b1, 0,   1);
        apb("slverr_rd",   32'h0000_0008, 1'b0, 32'h0,         4'h0,   1, 32'h55AA_55AA, 2'b10, 32'h0000_0000, 1'b1, 1,   3);
        apb("slverr_wr",   32'h0000_FFFC, 1'b1, 32'h0102_0304, 4'hF,   0, 32'h0,         2'b10, 32'h0000_0000, 1'b1, 1,   2);
        apb("status01",    32'h0000_FFFC, 1'b0, 32'h0,         4'hC,   4, 32'hA5A5_A5A5, 2'b01, 32'hA5A5_A5A5, 1'b0, 1,   6);
        apb("high_err",    32'hFFFF_0000, 1'b1, 32'h0000_0001, 4'h1,   0, 32'h0,         2'b00, 32'h0000_0000, 1'b1, 0,   1);

        // psel released mid-access: downstream completes, no pready follows.
        begin
            req_t r;
            rsp_delay = 3;
            rsp_data  = 32'h9999_9999;
            rsp_stat  = 2'b00;
            r.addr  = 16'h0020;
            r.dir   = 1'b0;
            r.wdata = 32'h0;
            r.strb  = 4'h0;
            req_q.push_back(r);
            @(posedge clk); #1;
            psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0020; pwrite = 1'b0; pwdata = '0; pstrb = '0;
            @(posedge clk); #1;
            penable = 1'b1;
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0;
            seen = 0;
            repeat (8) begin
                @(negedge clk);
                if (pready) seen++;
            end
            check("abort_no_pready", seen, 0);
        end

        // Asynchronous reset in the middle of a downstream access.
        begin
            req_t r;
            rsp_delay = -1;
            r.addr  = 16'h0030;
            r.dir   = 1'b1;
            r.wdata = 32'h0BAD_F00D;
            r.strb  = 4'hF;
            req_q.push_back(r);
            @(posedge clk); #1;
            psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0030; pwrite = 1'b1;
            pwdata = 32'h0BAD_F00D; pstrb = 4'hF;
            @(posedge clk); #1;
            penable = 1'b1;
            @(negedge clk);
            check("req_before_reset", bus_request, 1);
            #1 rst = 1'b1;
            #1;
            check("req_async_drop", bus_request, 0);
            check("addr_async_clear", bus_address, 0);
            check("pready_in_reset", pready, 0);
            @(posedge clk); #1;
            rst = 1'b0; psel = 1'b0; penable = 1'b0;
        end

        apb("after_reset", 32'h0000_0100, 1'b0, 32'h0,         4'h0,   0, 32'h0F0F_0F0F, 2'b00, 32'h0F0F_0F0F, 1'b0, 1,   2);

`ifdef RGGEN_APB_TIMEOUT_EN
        apb("timeout",     32'h0000_0040, 1'b0, 32'h0,         4'h0,  -1, 32'h0,         2'b00, 32'h0000_0000, 1'b1, 1,   9);
        apb("done_expiry", 32'h0000_0044, 1'b0, 32'h0,         4'h0,   7, 32'h600D_D00D, 2'b00, 32'h600D_D00D, 1'b0, 1,   9);
        apb("post_timeout",32'h0000_0048, 1'b1, 32'h1357_9BDF, 4'h5,   0, 32'h0,         2'b00, 32'h0000_0000, 1'b0, 1,   2);
`endif

        repeat (5) @(posedge clk);
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("req_queue_drained", req_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
